// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: state encodings and default
// PC/instruction geometry.
package ifetch_unit_pkg;

  localparam int unsigned IF_PC_W      = 10;
  localparam int unsigned IF_INSTR_W   = 32;
  localparam int unsigned IF_PC_STEP   = 4;
  localparam int unsigned IF_RESET_PC  = 0;
  localparam logic [IF_INSTR_W-1:0] IF_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_HOLD  = 2'd2
  } if_state_e;

endpackage

// File: rtl/ifetch_unit_skid.sv
// One-entry skid buffer: parks a fetched word and its PC while downstream stalls.
module ifetch_unit_skid
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned DATA_W = IF_INSTR_W,
  parameter int unsigned PC_W   = IF_PC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [PC_W-1:0]   pc_i,
  output logic [DATA_W-1:0] data_o,
  output logic [PC_W-1:0]   pc_o,
  output logic              full_o
);

  logic [DATA_W-1:0] buf_q;
  logic [PC_W-1:0]   pc_q;
  logic              full_q;

  // Clear wins over load so a redirect always discards the parked word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q  <= '0;
      pc_q   <= '0;
      full_q <= 1'b0;
    end else if (clear_i) begin
      full_q <= 1'b0;
    end else if (load_i) begin
      buf_q  <= data_i;
      pc_q   <= pc_i;
      full_q <= 1'b1;
    end
  end

  assign data_o = buf_q;
  assign pc_o   = pc_q;
  assign full_o = full_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory requests and
// presents instruction/PC/flush to REG1, absorbing wait states, stalls and redirects.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned     PC_W     = IF_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(IF_RESET_PC),
  parameter int unsigned     PC_STEP  = IF_PC_STEP
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic [PC_W-1:0]       oIM_addr,
  output logic                  oIM_enable,
  input  logic [IF_INSTR_W-1:0] iIM_data,
  input  logic                  iIM_ready,
  input  logic                  iIF_stall,
  input  logic                  iIF_redirect,
  input  logic [PC_W-1:0]       iIF_redirect_pc,
  output logic [IF_INSTR_W-1:0] oIF_instruction,
  output logic [PC_W-1:0]       oIF_current_pc,
  output logic                  oIF_valid,
  output logic                  oIF_flush_REG1
);

  if_state_e             state_q, state_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic [IF_INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]       cur_pc_q, cur_pc_d;
  logic                  valid_q, valid_d;

  logic                  skid_load;
  logic                  skid_clear;
  logic [IF_INSTR_W-1:0] skid_data;
  logic [PC_W-1:0]       skid_pc;
  logic                  skid_full;

  ifetch_unit_skid #(
    .DATA_W (IF_INSTR_W),
    .PC_W   (PC_W)
  ) u_skid (
    .clk     (clock),
    .rst_n   (reset_n),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .data_i  (iIM_data),
    .pc_i    (pc_q),
    .data_o  (skid_data),
    .pc_o    (skid_pc),
    .full_o  (skid_full)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IF_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= IF_NOP;
      cur_pc_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      cur_pc_q <= cur_pc_d;
      valid_q  <= valid_d;
    end
  end

  // Redirect overrides everything; otherwise stall freezes the presented outputs.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    cur_pc_d   = cur_pc_q;
    valid_d    = valid_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    if (iIF_redirect) begin
      pc_d       = iIF_redirect_pc;
      valid_d    = 1'b0;
      skid_clear = 1'b1;
      state_d    = IF_FETCH;
    end else begin
      unique case (state_q)
        IF_IDLE: begin
          state_d = IF_FETCH;
        end
        IF_FETCH: begin
          if (iIM_ready) begin
            pc_d = pc_q + PC_W'(PC_STEP);
            if (iIF_stall) begin
              skid_load = 1'b1;
              state_d   = IF_HOLD;
            end else begin
              instr_d  = iIM_data;
              cur_pc_d = pc_q;
              valid_d  = 1'b1;
            end
          end else if (!iIF_stall) begin
            valid_d = 1'b0;
          end
        end
        IF_HOLD: begin
          if (!iIF_stall) begin
            if (skid_full) begin
              instr_d  = skid_data;
              cur_pc_d = skid_pc;
              valid_d  = 1'b1;
            end
            skid_clear = 1'b1;
            state_d    = IF_FETCH;
          end
        end
        default: begin
          state_d = IF_IDLE;
        end
      endcase
    end
  end

  assign oIM_enable      = (state_q == IF_FETCH);
  assign oIM_addr        = pc_q;
  assign oIF_instruction = instr_q;
  assign oIF_current_pc  = cur_pc_q;
  assign oIF_valid       = valid_q;
  assign oIF_flush_REG1  = ~valid_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus a randomized run
// scored against an in-order PC-stream model with handshake invariants.
module tb_ifetch_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  oIM_addr;
  logic        oIM_enable;
  logic [31:0] iIM_data = 32'h0;
  logic        iIM_ready = 1'b0;
  logic        iIF_stall = 1'b0;
  logic        iIF_redirect = 1'b0;
  logic [9:0]  iIF_redirect_pc = 10'h0;
  logic [31:0] oIF_instruction;
  logic [9:0]  oIF_current_pc;
  logic        oIF_valid;
  logic        oIF_flush_REG1;

  int n_tests = 0;
  int n_fail  = 0;

  ifetch_unit dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .oIM_addr        (oIM_addr),
    .oIM_enable      (oIM_enable),
    .iIM_data        (iIM_data),
    .iIM_ready       (iIM_ready),
    .iIF_stall       (iIF_stall),
    .iIF_redirect    (iIF_redirect),
    .iIF_redirect_pc (iIF_redirect_pc),
    .oIF_instruction (oIF_instruction),
    .oIF_current_pc  (oIF_current_pc),
    .oIF_valid       (oIF_valid),
    .oIF_flush_REG1  (oIF_flush_REG1)
  );

  always #5 clock = ~clock;

  // Address-tagged instruction memory contents.
  function automatic logic [31:0] mem(input logic [9:0] a);
    return {16'hC0DE, 6'd0, a};
  endfunction

  // Expected snapshot: {enable, addr, valid, flush, current_pc, instruction}.
  function automatic logic [54:0] S(input logic en, input logic [9:0] addr, input logic v,
                                    input logic [9:0] pc, input logic [31:0] ins);
    return {en, addr, v, ~v, pc, ins};
  endfunction

  function automatic logic [54:0] snap();
    return {oIM_enable, oIM_addr, oIF_valid, oIF_flush_REG1, oIF_current_pc, oIF_instruction};
  endfunction

  // Drive one cycle of inputs at the falling edge, then advance to the next falling edge.
  task automatic tick(input logic rdy, input logic stl, input logic rd, input logic [9:0] tgt);
    iIM_ready       = rdy;
    iIF_stall       = stl;
    iIF_redirect    = rd;
    iIF_redirect_pc = tgt;
    iIM_data        = rdy ? mem(oIM_addr) : 32'hDEAD_BEEF;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    iIM_ready = 1'b0; iIF_stall = 1'b0; iIF_redirect = 1'b0; iIF_redirect_pc = 10'h0;
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [54:0] e;
    iIM_ready = 1'b1; iIF_stall = 1'b0; iIF_redirect = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    e = S(1'b0, 10'h0, 1'b0, 10'h0, 32'h0);
    n_tests++; if (snap() !== e) begin n_fail++; $display("FAIL reset_held: got %h want %h", snap(), e); end
    reset_n = 1'b1;
    n_tests++; if (snap() !== e) begin n_fail++; $display("FAIL reset_release: got %h want %h", snap(), e); end
  endtask

  task automatic test_sequential();
    logic [54:0] e;
    tick(1'b1, 1'b0, 1'b0, 10'h0);
    e = S(1'b1, 10'h000, 1'b0, 10'h0, 32'h0);
    n_tests++; if (snap() !== e) begin n_fail++; $display("FAIL seq_bubble: got %h want %h", snap(), e); end
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b0, 1'b0, 10'h0);
      e = S(1'b1, 10'(4 * (k + 1)), 1'b1, 10'(4 * k), mem(10'(4 * k)));
      n_tests++; if (snap() !== e) begin n_fail++; $display("FAIL seq_word%0d: got %h want %h", k, snap(), e); end
    end
  endtask

  task automatic test_wait_states();
    logic [54:0] e;
    do_reset();
    tick(1'b1, 1'b0, 1'b0, 10'h0);
    tick(1'b1, 1'b0, 1'b0, 10'h0);
    tick(1'b1, 1'b0, 1'b0, 10'h0);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0, 1'b0, 10'h0);
      e = S(1'b1, 10'h008, 1'b0, 10'h004, mem(10'h004));
      n_tests++; if (snap() !== e) begin n_fail++; $display("FAIL wait_bubble%0d: got %h want %h", k, snap(), e); end
    end
    tick(1'b1, 1'b0, 1'b0, 10'h0);
    e = S(1'b1, 10'h00C, 1'b1, 10'h008, mem(10'h008));
    n_tests++; if (snap() !== e) begin n_fail++; $display("FAIL wait_word8: got %h want %h", snap(), e); end
  endtask

  task automatic test_stall_hold();
    logic [54:0] e;
    do_reset();
    tick(1'b1, 1'b0, 1'b0, 10'h0);
    tick(1'b1, 1'b0, 1'b0, 10'h0);
    tick(1'b1, 1'b1, 1'b0, 10'h0);
    e = S(1'b0, 10'h008, 1'b1, 10'h000, mem(10'h000));
    n_tests++; if (snap() !== e) begin n_fail++; $display("FAIL stall_cycle1: got %h want %h", snap(), e); end
    tick(1'b0, 1'b1, 1'b0, 10'h0);
    n_tests++; if (snap() !== e) begin n_fail++; $display("FAIL stall_cycle2: got %h want %h", snap(), e); end
    tick(1'b0, 1'b0, 1'b0, 10'h0);
    e = S(1'b1, 10'h008, 1'b1, 10'h004, mem(10'h004));
    n_tests++; if (snap() !== e) begin n_fail++; $display("FAIL stall_release: got %h want %h", snap(), e); end
    tick(1'b1, 1'b0, 1'b0, 10'h0);
    e = S(1'b1, 10'h00C, 1'b1, 10'h008, mem(10'h008));
    n_tests++; if (snap() !== e) begin n_fail++; $display("FAIL stall_resume: got %h want %h", snap(), e); end
  endtask

  task automatic test_redirect_hold();
    logic [54:0] e;
    do_reset();
    tick(1'b1, 1'b0, 1'b0, 10'h0);
    tick(1'b1, 1'b0, 1'b0, 10'h0);
    tick(1'b1, 1'b1, 1'b0, 10'h0);
    tick(1'b0, 1'b1, 1'b1, 10'h100);
    e = S(1'b1, 10'h100, 1'b0, 10'h000, mem(10'h000));
    n_tests++; if (snap() !== e) begin n_fail++; $display("FAIL redir_flush: got %h want %h", snap(), e); end
    tick(1'b1, 1'b0, 1'b0, 10'h0);
    e = S(1'b1, 10'h104, 1'b1, 10'h100, mem(10'h100));
    n_tests++; if (snap() !== e) begin n_fail++; $display("FAIL redir_target: got %h want %h", snap(), e); end
    tick(1'b1, 1'b0, 1'b0, 10'h0);
    e = S(1'b1, 10'h108, 1'b1, 10'h104, mem(10'h104));
    n_tests++; if (snap() !== e) begin n_fail++; $display("FAIL redir_next: got %h want %h", snap(), e); end
  endtask

  task automatic test_wrap();
    logic [54:0] e;
    do_reset();
    tick(1'b1, 1'b0, 1'b0, 10'h0);
    tick(1'b1, 1'b0, 1'b1, 10'h3F8);
    e = S(1'b1, 10'h3F8, 1'b0, 10'h000, 32'h0);
    n_tests++; if (snap() !== e) begin n_fail++; $display("FAIL wrap_redirect: got %h want %h", snap(), e); end
    tick(1'b1, 1'b0, 1'b0, 10'h0);
    tick(1'b1, 1'b0, 1'b0, 10'h0);
    e = S(1'b1, 10'h000, 1'b1, 10'h3FC, mem(10'h3FC));
    n_tests++; if (snap() !== e) begin n_fail++; $display("FAIL wrap_addr: got %h want %h", snap(), e); end
    tick(1'b1, 1'b0, 1'b0, 10'h0);
    e = S(1'b1, 10'h004, 1'b1, 10'h000, mem(10'h000));
    n_tests++; if (snap() !== e) begin n_fail++; $display("FAIL wrap_pc: got %h want %h", snap(), e); end
  endtask

  task automatic test_async_reset();
    logic [54:0] e;
    do_reset();
    tick(1'b1, 1'b0, 1'b0, 10'h0);
    tick(1'b1, 1'b0, 1'b0, 10'h0);
    tick(1'b1, 1'b0, 1'b0, 10'h0);
    tick(1'b0, 1'b0, 1'b0, 10'h0);
    #2 reset_n = 1'b0;
    #1;
    e = S(1'b0, 10'h0, 1'b0, 10'h0, 32'h0);
    n_tests++; if (snap() !== e) begin n_fail++; $display("FAIL areset_immediate: got %h want %h", snap(), e); end
    @(negedge clock);
    reset_n = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 10'h0);
    e = S(1'b1, 10'h000, 1'b0, 10'h0, 32'h0);
    n_tests++; if (snap() !== e) begin n_fail++; $display("FAIL areset_restart: got %h want %h", snap(), e); end
    tick(1'b1, 1'b0, 1'b0, 10'h0);
    e = S(1'b1, 10'h004, 1'b1, 10'h000, mem(10'h000));
    n_tests++; if (snap() !== e) begin n_fail++; $display("FAIL areset_first: got %h want %h", snap(), e); end
  endtask

  // Random traffic: presented PCs must form the in-order stream implied by consumption
  // (valid && !stall) and redirects; stalls freeze outputs; requests never retract.
  task automatic test_random();
    logic        rdy, stl, rd, p_v, p_en;
    logic [9:0]  tgt, exp_pc, p_pc, p_addr;
    logic [31:0] p_ins;
    int          good;
    do_reset();
    exp_pc = 10'h000;
    good   = 0;
    for (int i = 0; i < 3000; i++) begin
      rdy = ($urandom_range(9, 0) < 7);
      stl = ($urandom_range(3, 0) == 0);
      rd  = ($urandom_range(15, 0) == 0);
      tgt = 10'($urandom_range(255, 0) * 4);
      p_v = oIF_valid; p_pc = oIF_current_pc; p_ins = oIF_instruction;
      p_en = oIM_enable; p_addr = oIM_addr;
      if (rd) exp_pc = tgt;
      else if (p_v && !stl) exp_pc = exp_pc + 10'd4;
      good = (rdy && !stl && !rd) ? good + 1 : 0;
      tick(rdy, stl, rd, tgt);
      n_tests++; if (oIF_flush_REG1 !== ~oIF_valid) begin n_fail++;
        $display("FAIL rnd_flush c%0d: got flush %b valid %b", i, oIF_flush_REG1, oIF_valid); end
      if (oIF_valid === 1'b1) begin
        n_tests++; if ({oIF_current_pc, oIF_instruction} !== {exp_pc, mem(exp_pc)}) begin n_fail++;
          $display("FAIL rnd_stream c%0d: got %h/%h want %h/%h", i, oIF_current_pc, oIF_instruction, exp_pc, mem(exp_pc)); end
      end
      if (rd) begin
        n_tests++; if (oIF_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_redir c%0d: got valid %b want 0", i, oIF_valid); end
      end else if (stl) begin
        n_tests++; if ({oIF_valid, oIF_current_pc, oIF_instruction} !== {p_v, p_pc, p_ins}) begin n_fail++;
          $display("FAIL rnd_stall c%0d: got %h want %h", i, {oIF_valid, oIF_current_pc, oIF_instruction}, {p_v, p_pc, p_ins}); end
      end
      if (!rd && p_en && !rdy) begin
        n_tests++; if ({oIM_enable, oIM_addr} !== {1'b1, p_addr}) begin n_fail++;
          $display("FAIL rnd_hold_req c%0d: got %b/%h want 1/%h", i, oIM_enable, oIM_addr, p_addr); end
      end
      if (good >= 2) begin
        n_tests++; if (oIF_valid !== 1'b1) begin n_fail++; $display("FAIL rnd_throughput c%0d: got valid %b want 1", i, oIF_valid); end
      end
    end
    iIF_stall = 1'b0; iIF_redirect = 1'b0; iIM_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_states();
    test_stall_hold();
    test_redirect_hold();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish by %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
